// File: rtl/score_update_sequencer.sv
// Purpose : owns both player scores, counts goal edges, and commits them to the score
//           sprite controller only during vertical blanking; latches the game-over condition.
// Latency : goal edge in c0 with vblank high -> APPLY c2, writes (addr 00, 01) in c3/c4.
// Backpr. : none; goals wait in saturating pending counters until the next vblank.
// Ports   : clk, rst (async, active-high)
//           goal_p1_i, goal_p2_i  goal pulses (rising edge = one goal)
//           vblank_i              vertical blanking level
//           game_reset_i          level; clears scores and game-over, forces a zero write
//           MW_o, address_o, data_o   registered write port to the score controller
//           score1_o, score2_o    committed scores
//           game_over_o, winner_o win latch (winner: 01 P1, 10 P2, 11 draw)
//           busy_o                high while a commit is pending or in progress
module score_update_sequencer #(
   parameter int WIN_SCORE = 5,
   parameter int PEND_W    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        goal_p1_i,
   input  logic        goal_p2_i,
   input  logic        vblank_i,
   input  logic        game_reset_i,
   output logic        MW_o,
   output logic [1:0]  address_o,
   output logic [31:0] data_o,
   output logic [3:0]  score1_o,
   output logic [3:0]  score2_o,
   output logic        game_over_o,
   output logic [1:0]  winner_o,
   output logic        busy_o
);

   localparam logic [3:0]        WIN      = 4'(WIN_SCORE);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   typedef enum logic [2:0] {IDLE, WAIT_VB, APPLY, WR_S1, WR_S2, GAME_OVER} state_t;

   state_t            state, state_nxt;
   logic              goal_q1, goal_q2;
   logic [PEND_W-1:0] pend1, pend2, pend1_nxt, pend2_nxt;
   logic [3:0]        score1_nxt, score2_nxt;
   logic              inc1, inc2, dec1, dec2;
   logic              mw_nxt, go_nxt;
   logic [1:0]        addr_nxt, winner_nxt;
   logic [31:0]       data_nxt;

   // Decrement for the goal being applied, then add the new edge unless that would overflow.
   // At saturation an APPLY plus a same-cycle edge leaves the count unchanged.
   function automatic logic [PEND_W-1:0] pend_update(input logic [PEND_W-1:0] p,
                                                     input logic inc, input logic dec);
      logic [PEND_W-1:0] base;
      base = dec ? p - 1'b1 : p;
      if (inc && base != PEND_MAX)
         base = base + 1'b1;
      return base;
   endfunction

   // Edges are discarded during game reset and while the game is over.
   assign inc1 = goal_p1_i & ~goal_q1 & ~game_reset_i & (state != GAME_OVER);
   assign inc2 = goal_p2_i & ~goal_q2 & ~game_reset_i & (state != GAME_OVER);
   assign dec1 = (state == APPLY) && (pend1 != '0);
   assign dec2 = (state == APPLY) && (pend2 != '0);

   assign busy_o = (state != IDLE) && (state != GAME_OVER);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; game reset overrides everything and parks the FSM in WAIT_VB.
   // IDLE also looks at this cycle's edge so a goal reaches WAIT_VB one cycle later.
   always_comb begin
      state_nxt = state;
      if (game_reset_i) begin
         state_nxt = WAIT_VB;
      end else begin
         case (state)
            IDLE:      if (pend1 != '0 || pend2 != '0 || inc1 || inc2) state_nxt = WAIT_VB;
            WAIT_VB:   if (vblank_i) state_nxt = APPLY;
            APPLY:     state_nxt = WR_S1;
            WR_S1:     state_nxt = WR_S2;
            WR_S2: begin
               if (score1_o == WIN || score2_o == WIN)
                  state_nxt = GAME_OVER;
               else if (pend1 != '0 || pend2 != '0 || inc1 || inc2)
                  state_nxt = WAIT_VB;
               else
                  state_nxt = IDLE;
            end
            GAME_OVER: state_nxt = GAME_OVER;
            default:   state_nxt = IDLE;
         endcase
      end
   end

   // Output / datapath next values. Write-port values are derived from the next state so
   // the registered strobe lines up with WR_S1/WR_S2 and carries the freshly applied score.
   always_comb begin
      score1_nxt = score1_o;
      score2_nxt = score2_o;
      if (game_reset_i) begin
         score1_nxt = 4'd0;
         score2_nxt = 4'd0;
      end else if (state == APPLY) begin
         if (pend1 != '0 && score1_o < WIN) score1_nxt = score1_o + 4'd1;
         if (pend2 != '0 && score2_o < WIN) score2_nxt = score2_o + 4'd1;
      end

      if (game_reset_i || state == GAME_OVER || state_nxt == GAME_OVER) begin
         pend1_nxt = '0;
         pend2_nxt = '0;
      end else begin
         pend1_nxt = pend_update(pend1, inc1, dec1);
         pend2_nxt = pend_update(pend2, inc2, dec2);
      end

      mw_nxt   = 1'b0;
      addr_nxt = address_o;
      data_nxt = data_o;
      if (state_nxt == WR_S1) begin
         mw_nxt   = 1'b1;
         addr_nxt = 2'b00;
         data_nxt = {28'd0, score1_nxt};
      end else if (state_nxt == WR_S2) begin
         mw_nxt   = 1'b1;
         addr_nxt = 2'b01;
         data_nxt = {28'd0, score2_nxt};
      end

      go_nxt     = game_over_o;
      winner_nxt = winner_o;
      if (game_reset_i) begin
         go_nxt     = 1'b0;
         winner_nxt = 2'b00;
      end else if (state == WR_S2 && state_nxt == GAME_OVER) begin
         go_nxt     = 1'b1;
         winner_nxt = {score2_o == WIN, score1_o == WIN};
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         goal_q1     <= 1'b0;
         goal_q2     <= 1'b0;
         pend1       <= '0;
         pend2       <= '0;
         score1_o    <= 4'd0;
         score2_o    <= 4'd0;
         MW_o        <= 1'b0;
         address_o   <= 2'b00;
         data_o      <= 32'd0;
         game_over_o <= 1'b0;
         winner_o    <= 2'b00;
      end else begin
         goal_q1     <= goal_p1_i;
         goal_q2     <= goal_p2_i;
         pend1       <= pend1_nxt;
         pend2       <= pend2_nxt;
         score1_o    <= score1_nxt;
         score2_o    <= score2_nxt;
         MW_o        <= mw_nxt;
         address_o   <= addr_nxt;
         data_o      <= data_nxt;
         game_over_o <= go_nxt;
         winner_o    <= winner_nxt;
      end
   end

endmodule

// File: tb/tb_score_update_sequencer.sv
module tb_score_update_sequencer;

   logic        clk, rst;
   logic        goal_p1_i, goal_p2_i, vblank_i, game_reset_i;
   logic        MW_o;
   logic [1:0]  address_o;
   logic [31:0] data_o;
   logic [3:0]  score1_o, score2_o;
   logic        game_over_o;
   logic [1:0]  winner_o;
   logic        busy_o;

   int passed = 0;
   int total  = 0;

   score_update_sequencer #(.WIN_SCORE(5), .PEND_W(2)) dut (
      .clk(clk), .rst(rst),
      .goal_p1_i(goal_p1_i), .goal_p2_i(goal_p2_i),
      .vblank_i(vblank_i), .game_reset_i(game_reset_i),
      .MW_o(MW_o), .address_o(address_o), .data_o(data_o),
      .score1_o(score1_o), .score2_o(score2_o),
      .game_over_o(game_over_o), .winner_o(winner_o), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   typedef struct {
      logic        g1, g2, vb, gr;
      logic        mw;
      logic [1:0]  addr;
      logic [31:0] data;
      logic [3:0]  s1, s2;
      logic        go;
      logic [1:0]  win;
      logic        busy;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic g1, input logic g2, input logic vb, input logic gr,
                               input logic mw, input logic [1:0] a, input logic [31:0] d,
                               input logic [3:0] s1, input logic [3:0] s2,
                               input logic go, input logic [1:0] w, input logic b);
      vec_t v;
      v.g1 = g1; v.g2 = g2; v.vb = vb; v.gr = gr;
      v.mw = mw; v.addr = a; v.data = d; v.s1 = s1; v.s2 = s2;
      v.go = go; v.win = w; v.busy = b;
      return v;
   endfunction

   function automatic logic [63:0] act_pack();
      return {17'd0, MW_o, address_o, data_o, score1_o, score2_o, game_over_o, winner_o, busy_o};
   endfunction

   function automatic logic [63:0] exp_pack(input vec_t v);
      return {17'd0, v.mw, v.addr, v.data, v.s1, v.s2, v.go, v.win, v.busy};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name, input int limit);
      logic done;
      done = 1'b0;
      for (int n = 0; n < limit; n++) begin
         tick();
         if (!busy_o) begin
            done = 1'b1;
            break;
         end
      end
      chk(name, 64'(done), 64'd1);
   endtask

   task automatic do_goal(input logic p1, input logic p2);
      tick();
      goal_p1_i = p1;
      goal_p2_i = p2;
      tick();
      goal_p1_i = 1'b0;
      goal_p2_i = 1'b0;
      wait_idle("goal_done", 20);
   endtask

   initial begin
      logic mw_seen;
      // Rows: inputs driven for cycle i, expected outputs observed in cycle i (before driving).
      //                g1 g2 vb gr  mw  addr   data   s1    s2   go  win   busy
      vecs[0]  = mk(H, L, H, L,  L, 2'd0, 32'd0, 4'd0, 4'd0, L, 2'd0, L);
      vecs[1]  = mk(L, L, H, L,  L, 2'd0, 32'd0, 4'd0, 4'd0, L, 2'd0, H);
      vecs[2]  = mk(L, L, H, L,  L, 2'd0, 32'd0, 4'd0, 4'd0, L, 2'd0, H);
      vecs[3]  = mk(L, L, H, L,  H, 2'd0, 32'd1, 4'd1, 4'd0, L, 2'd0, H);
      vecs[4]  = mk(L, L, H, L,  H, 2'd1, 32'd0, 4'd1, 4'd0, L, 2'd0, H);
      vecs[5]  = mk(L, L, H, L,  L, 2'd1, 32'd0, 4'd1, 4'd0, L, 2'd0, L);
      vecs[6]  = mk(L, H, L, L,  L, 2'd1, 32'd0, 4'd1, 4'd0, L, 2'd0, L);
      vecs[7]  = mk(L, L, L, L,  L, 2'd1, 32'd0, 4'd1, 4'd0, L, 2'd0, H);
      vecs[8]  = mk(L, H, L, L,  L, 2'd1, 32'd0, 4'd1, 4'd0, L, 2'd0, H);
      vecs[9]  = mk(L, L, L, L,  L, 2'd1, 32'd0, 4'd1, 4'd0, L, 2'd0, H);
      vecs[10] = mk(L, H, L, L,  L, 2'd1, 32'd0, 4'd1, 4'd0, L, 2'd0, H);
      vecs[11] = mk(L, L, L, L,  L, 2'd1, 32'd0, 4'd1, 4'd0, L, 2'd0, H);
      vecs[12] = mk(L, L, H, L,  L, 2'd1, 32'd0, 4'd1, 4'd0, L, 2'd0, H);
      vecs[13] = mk(L, L, H, L,  L, 2'd1, 32'd0, 4'd1, 4'd0, L, 2'd0, H);
      vecs[14] = mk(L, L, H, L,  H, 2'd0, 32'd1, 4'd1, 4'd1, L, 2'd0, H);
      vecs[15] = mk(L, L, H, L,  H, 2'd1, 32'd1, 4'd1, 4'd1, L, 2'd0, H);
      vecs[16] = mk(L, L, H, L,  L, 2'd1, 32'd1, 4'd1, 4'd1, L, 2'd0, H);
      vecs[17] = mk(L, L, H, L,  L, 2'd1, 32'd1, 4'd1, 4'd1, L, 2'd0, H);
      vecs[18] = mk(L, L, H, L,  H, 2'd0, 32'd1, 4'd1, 4'd2, L, 2'd0, H);
      vecs[19] = mk(L, L, H, L,  H, 2'd1, 32'd2, 4'd1, 4'd2, L, 2'd0, H);
      vecs[20] = mk(L, L, H, L,  L, 2'd1, 32'd2, 4'd1, 4'd2, L, 2'd0, H);
      vecs[21] = mk(L, L, H, L,  L, 2'd1, 32'd2, 4'd1, 4'd2, L, 2'd0, H);
      vecs[22] = mk(L, L, H, L,  H, 2'd0, 32'd1, 4'd1, 4'd3, L, 2'd0, H);
      vecs[23] = mk(L, L, H, L,  H, 2'd1, 32'd3, 4'd1, 4'd3, L, 2'd0, H);
      vecs[24] = mk(L, L, H, L,  L, 2'd1, 32'd3, 4'd1, 4'd3, L, 2'd0, L);

      rst = 1'b1;
      goal_p1_i = 1'b0; goal_p2_i = 1'b0; vblank_i = 1'b1; game_reset_i = 1'b0;
      tick();
      tick();
      chk("reset_state", act_pack(), 64'd0);
      rst = 1'b0;

      // Single P1 goal latency, then three P2 goals queued outside vblank.
      for (int i = 0; i < NV; i++) begin
         tick();
         chk($sformatf("vec%0d", i), act_pack(), exp_pack(vecs[i]));
         goal_p1_i    = vecs[i].g1;
         goal_p2_i    = vecs[i].g2;
         vblank_i     = vecs[i].vb;
         game_reset_i = vecs[i].gr;
      end

      // Bring scores to 4/4, then a simultaneous goal gives a draw.
      do_goal(1'b1, 1'b0);
      do_goal(1'b1, 1'b0);
      do_goal(1'b1, 1'b0);
      do_goal(1'b0, 1'b1);
      chk("scores_4_4", 64'({score1_o, score2_o}), 64'({4'd4, 4'd4}));
      tick(); goal_p1_i = 1'b1; goal_p2_i = 1'b1;
      tick(); goal_p1_i = 1'b0; goal_p2_i = 1'b0;
      tick();
      tick();
      chk("draw_wr1", 64'({MW_o, address_o, data_o}), 64'({1'b1, 2'b00, 32'd5}));
      tick();
      chk("draw_wr2", 64'({MW_o, address_o, data_o, game_over_o}), 64'({1'b1, 2'b01, 32'd5, 1'b0}));
      tick();
      chk("draw_over", 64'({game_over_o, winner_o, busy_o, score1_o, score2_o}),
          64'({1'b1, 2'b11, 1'b0, 4'd5, 4'd5}));
      tick(); goal_p1_i = 1'b1;
      tick(); goal_p1_i = 1'b0;
      mw_seen = 1'b0;
      for (int n = 0; n < 6; n++) begin
         tick();
         if (MW_o || busy_o) mw_seen = 1'b1;
      end
      chk("over_ignores_goal", 64'({mw_seen, game_over_o, score1_o}), 64'({1'b0, 1'b1, 4'd5}));

      // One-cycle game reset from game over: zero writes, latch cleared.
      tick(); game_reset_i = 1'b1;
      tick(); game_reset_i = 1'b0;
      chk("greset_c1", act_pack(), 64'({17'd0, 1'b0, 2'b01, 32'd5, 4'd0, 4'd0, 1'b0, 2'b00, 1'b1}));
      tick();
      tick();
      chk("greset_wr1", 64'({MW_o, address_o, data_o}), 64'({1'b1, 2'b00, 32'd0}));
      tick();
      chk("greset_wr2", 64'({MW_o, address_o, data_o}), 64'({1'b1, 2'b01, 32'd0}));
      tick();
      chk("greset_idle", 64'({busy_o, game_over_o, winner_o}), 64'({1'b0, 1'b0, 2'b00}));

      // P1 alone reaches the win score.
      for (int n = 0; n < 5; n++) do_goal(1'b1, 1'b0);
      chk("p1_wins", 64'({game_over_o, winner_o, score1_o, score2_o}),
          64'({1'b1, 2'b01, 4'd5, 4'd0}));

      // Held game reset parks in WAIT_VB without writing, then zero writes after release.
      tick(); game_reset_i = 1'b1;
      tick();
      chk("hold_c1", 64'({MW_o, busy_o, game_over_o, winner_o}), 64'({1'b0, 1'b1, 1'b0, 2'b00}));
      tick(); game_reset_i = 1'b0;
      chk("hold_c2", 64'({MW_o, busy_o}), 64'({1'b0, 1'b1}));
      tick();
      tick();
      chk("hold_wr1", 64'({MW_o, address_o, data_o}), 64'({1'b1, 2'b00, 32'd0}));
      tick();
      chk("hold_wr2", 64'({MW_o, address_o, data_o}), 64'({1'b1, 2'b01, 32'd0}));
      wait_idle("hold_done", 10);

      // Goal held high for 10 cycles counts once.
      tick(); goal_p1_i = 1'b1;
      repeat (10) tick();
      goal_p1_i = 1'b0;
      wait_idle("held_done", 20);
      chk("held_one_goal", 64'({score1_o, score2_o}), 64'({4'd1, 4'd0}));

      // Async reset in WR_S1 clears outputs immediately.
      tick(); goal_p1_i = 1'b1;
      tick(); goal_p1_i = 1'b0;
      tick();
      tick();
      chk("pre_rst_wr1", 64'({MW_o, address_o, data_o}), 64'({1'b1, 2'b00, 32'd2}));
      rst = 1'b1;
      #1;
      chk("async_rst", act_pack(), 64'd0);
      tick();
      rst = 1'b0;

      // Four goals outside vblank saturate the pending count at three.
      vblank_i = 1'b0;
      for (int n = 0; n < 4; n++) begin
         tick(); goal_p1_i = 1'b1;
         tick(); goal_p1_i = 1'b0;
      end
      tick();
      chk("sat_no_write", 64'({MW_o, score1_o}), 64'({1'b0, 4'd0}));
      vblank_i = 1'b1;
      wait_idle("sat_done", 60);
      chk("sat_score", 64'(score1_o), 64'd3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
